psram_ctrl: RTL



---
 rtl/psram_pkg.sv | 45 ++++
 rtl/psram_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/psram_pkg.sv
// Shared constants, FSM state encoding and address helper for the PSRAM controller.
package psram_pkg;

    localparam int         INIT_WAIT_CYCLES = 3;
    localparam int         READ_WAIT_CYCLES = 5;
    localparam int         ADDR_NIBBLES     = 6;
    localparam int         CMD_BITS         = 8;
    localparam int         DATA_BYTES       = 2;

    localparam logic [7:0] CMD_QPI_ENTER    = 8'h35;
    localparam logic [7:0] CMD_WR0          = 8'h33;
    localparam logic [7:0] CMD_WR1          = 8'h88;
    localparam logic [7:0] CMD_RD0          = 8'hEE;
    localparam logic [7:0] CMD_RD1          = 8'hBB;

    typedef enum logic [3:0] {
        ST_INIT_WAIT  = 4'd0,
        ST_INIT_CMD   = 4'd1,
        ST_INIT_DESEL = 4'd2,
        ST_IDLE       = 4'd3,
        ST_CMD0       = 4'd4,
        ST_CMD1       = 4'd5,
        ST_ADDR       = 4'd6,
        ST_WDATA      = 4'd7,
        ST_RWAIT      = 4'd8,
        ST_RDATA      = 4'd9,
        ST_DESEL      = 4'd10
    } state_e;

    // Address goes out most-significant nibble first.
    function automatic logic [3:0] addr_nibble(input logic [23:0] addr, input logic [3:0] idx);
        logic [3:0] nib;
        case (idx)
            4'd0:    nib = addr[23:20];
            4'd1:    nib = addr[19:16];
            4'd2:    nib = addr[15:12];
            4'd3:    nib = addr[11:8];
            4'd4:    nib = addr[7:4];
            4'd5:    nib = addr[3:0];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/psram_ctrl.sv
// Single-requester PSRAM controller: QPI-mode entry after reset, then 16-bit
// read/write transactions (command, address nibbles, wait, two data bytes).
module psram_ctrl
    import psram_pkg::*;
(
    input  logic        psram_sclk,
    input  logic        arst_n,
    output logic        init_done,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_done,
    output logic [15:0] rsp_rdata,
    output logic        psram_csn,
    output logic [7:0]  psram_dq_o,
    output logic        psram_dq_oe,
    input  logic [7:0]  psram_dq_i
);

    localparam logic [3:0] LAST_INIT_WAIT = 4'(INIT_WAIT_CYCLES - 1);
    localparam logic [3:0] LAST_CMD_BIT   = 4'(CMD_BITS - 1);
    localparam logic [3:0] LAST_NIBBLE    = 4'(ADDR_NIBBLES - 1);
    localparam logic [3:0] LAST_RWAIT     = 4'(READ_WAIT_CYCLES - 1);
    localparam logic [3:0] LAST_BYTE      = 4'(DATA_BYTES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  rd_lo_q, rd_lo_d;
    logic [15:0] rdata_q, rdata_d;
    logic        csn_q, csn_d;
    logic        oe_q, oe_d;
    logic [7:0]  dq_q, dq_d;
    logic        rsp_done_q, rsp_done_d;
    logic        req_ready_q, req_ready_d;
    logic        init_done_q, init_done_d;

    // Next-state, shared counter and request/read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_lo_d = rd_lo_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_INIT_WAIT: begin
                if (cnt_q == LAST_INIT_WAIT) begin
                    state_d = ST_INIT_CMD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_INIT_CMD: begin
                if (cnt_q == LAST_CMD_BIT) begin
                    state_d = ST_INIT_DESEL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_INIT_DESEL: state_d = ST_IDLE;
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d = ST_CMD0;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD0: state_d = ST_CMD1;
            ST_CMD1: state_d = ST_ADDR;
            ST_ADDR: begin
                if (cnt_q == LAST_NIBBLE) begin
                    state_d = we_q ? ST_WDATA : ST_RWAIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WDATA: begin
                if (cnt_q == LAST_BYTE) begin
                    state_d = ST_DESEL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RWAIT: begin
                if (cnt_q == LAST_RWAIT) begin
                    state_d = ST_RDATA;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RDATA: begin
                // Low byte arrives first; the full word is published together.
                if (cnt_q == LAST_BYTE) begin
                    state_d = ST_DESEL;
                    rdata_d = {psram_dq_i, rd_lo_q};
                end else begin
                    rd_lo_d = psram_dq_i;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_DESEL: state_d = ST_IDLE;
            default:  state_d = ST_INIT_WAIT;
        endcase
    end

    // Pad and handshake outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        csn_d       = 1'b1;
        oe_d        = 1'b0;
        dq_d        = 8'h00;
        rsp_done_d  = 1'b0;
        req_ready_d = 1'b0;
        init_done_d = init_done_q;
        case (state_d)
            ST_INIT_CMD: begin
                csn_d = 1'b0;
                oe_d  = 1'b1;
                dq_d  = {7'b0, CMD_QPI_ENTER[3'(4'd7 - cnt_d)]};
            end
            ST_IDLE: begin
                req_ready_d = 1'b1;
                init_done_d = 1'b1;
            end
            ST_CMD0: begin
                csn_d = 1'b0;
                oe_d  = 1'b1;
                dq_d  = we_d ? CMD_WR0 : CMD_RD0;
            end
            ST_CMD1: begin
                csn_d = 1'b0;
                oe_d  = 1'b1;
                dq_d  = we_d ? CMD_WR1 : CMD_RD1;
            end
            ST_ADDR: begin
                csn_d = 1'b0;
                oe_d  = 1'b1;
                dq_d  = {4'h0, addr_nibble(addr_d, cnt_d)};
            end
            ST_WDATA: begin
                csn_d = 1'b0;
                oe_d  = 1'b1;
                dq_d  = (cnt_d == 4'd0) ? wdata_d[7:0] : wdata_d[15:8];
            end
            ST_RWAIT, ST_RDATA: begin
                csn_d = 1'b0;
            end
            ST_DESEL: begin
                rsp_done_d = 1'b1;
            end
            default: begin
                csn_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset also aborts any bus transaction in flight.
    always_ff @(posedge psram_sclk) begin
        if (!arst_n) begin
            state_q     <= ST_INIT_WAIT;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 24'h000000;
            wdata_q     <= 16'h0000;
            rd_lo_q     <= 8'h00;
            rdata_q     <= 16'h0000;
            csn_q       <= 1'b1;
            oe_q        <= 1'b0;
            dq_q        <= 8'h00;
            rsp_done_q  <= 1'b0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_lo_q     <= rd_lo_d;
            rdata_q     <= rdata_d;
            csn_q       <= csn_d;
            oe_q        <= oe_d;
            dq_q        <= dq_d;
            rsp_done_q  <= rsp_done_d;
            req_ready_q <= req_ready_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done   = init_done_q;
    assign req_ready   = req_ready_q;
    assign rsp_done    = rsp_done_q;
    assign rsp_rdata   = rdata_q;
    assign psram_csn   = csn_q;
    assign psram_dq_o  = dq_q;
    assign psram_dq_oe = oe_q;

endmodule
